// File: rtl/sign_narrowing_unit_pkg.sv
// -----------------------------------------------------------------------------
// sign_narrowing_unit_pkg
// Shared definitions for the store-path narrowing unit: access-size
// encodings, byte-enable constants and saturation limits.
// Optional feature macro: SIGN_NARROW_SAT_EN. When it is defined, the
// saturation limits below are used to clamp overflowing values.
// -----------------------------------------------------------------------------
package sign_narrowing_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    localparam logic [7:0]  SAT_S8_MAX  = 8'h7F;
    localparam logic [7:0]  SAT_S8_MIN  = 8'h80;
    localparam logic [7:0]  SAT_U8_MAX  = 8'hFF;
    localparam logic [15:0] SAT_S16_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_S16_MIN = 16'h8000;
    localparam logic [15:0] SAT_U16_MAX = 16'hFFFF;

endpackage

// File: rtl/sign_narrowing_unit_check.sv
// -----------------------------------------------------------------------------
// narrow_range_check
// Combinational range check for store narrowing. Decides whether the
// 32-bit register value is representable in the target width (signed or
// unsigned) and produces the narrowed value, right-justified.
// Optional feature macro: SIGN_NARROW_SAT_EN (clamp instead of truncate).
//
// Ports:
//   data      in  32  register value
//   size      in  2   access size (byte/half/word/reserved)
//   is_signed in  1   1 = signed range, 0 = unsigned range
//   ovf       out 1   value not representable in the target width
//   narrowed  out 32  narrowed value in the low bits (word: unchanged)
// -----------------------------------------------------------------------------
module narrow_range_check
    import sign_narrowing_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic        ovf,
    output logic [31:0] narrowed
);

`ifdef SIGN_NARROW_SAT_EN
    // Overflow direction follows the sign of the full 32-bit value.
    function automatic logic [7:0] clamp_byte(input logic neg, input logic sgn);
        if (!sgn)
            return SAT_U8_MAX;
        return neg ? SAT_S8_MIN : SAT_S8_MAX;
    endfunction

    function automatic logic [15:0] clamp_half(input logic neg, input logic sgn);
        if (!sgn)
            return SAT_U16_MAX;
        return neg ? SAT_S16_MIN : SAT_S16_MAX;
    endfunction
`endif

    always_comb begin
        ovf      = 1'b0;
        narrowed = data;
        case (size)
            SZ_BYTE: begin
                // Signed fits only if bits 31..7 are a pure sign extension.
                if (is_signed)
                    ovf = !((&data[31:7]) || !(|data[31:7]));
                else
                    ovf = |data[31:8];
                narrowed = {24'b0, data[7:0]};
`ifdef SIGN_NARROW_SAT_EN
                if (ovf)
                    narrowed = {24'b0, clamp_byte(data[31], is_signed)};
`endif
            end
            SZ_HALF: begin
                if (is_signed)
                    ovf = !((&data[31:15]) || !(|data[31:15]));
                else
                    ovf = |data[31:16];
                narrowed = {16'b0, data[15:0]};
`ifdef SIGN_NARROW_SAT_EN
                if (ovf)
                    narrowed = {16'b0, clamp_half(data[31], is_signed)};
`endif
            end
            default: begin
                ovf      = 1'b0;
                narrowed = data;
            end
        endcase
    end

endmodule

// File: rtl/sign_narrowing_unit.sv
// -----------------------------------------------------------------------------
// sign_narrowing_unit
// Store-path narrowing between EX/MEM and data memory. Range-checks the
// register value for byte/half stores, lane-aligns it onto the 32-bit store
// bus, generates byte enables, flags misalignment, and counts overflowing
// beats in a saturating debug counter. One registered stage with a
// valid/ready handshake (latency 1, full throughput).
// Optional feature macro: SIGN_NARROW_SAT_EN (saturate instead of truncate).
//
// Parameters:
//   CNT_W          width of the overflow event counter
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_data        32-bit register value
//   in_size        00 byte, 01 half, 10 word, 11 reserved
//   in_signed      1 signed range check, 0 unsigned
//   in_addr        low address bits for lane placement
//   out_valid/out_ready  output handshake
//   out_data       lane-aligned narrowed data
//   out_be         byte enables, bit i = lane i
//   out_ovf        value not representable in the target width
//   out_misalign   misaligned address for the size, or reserved size
//   ovf_count      saturating count of accepted overflowing, aligned beats
// -----------------------------------------------------------------------------
module sign_narrowing_unit
    import sign_narrowing_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    input  logic [1:0]       in_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_be,
    output logic             out_ovf,
    output logic             out_misalign,
    output logic [CNT_W-1:0] ovf_count
);

    logic             rc_ovf;
    logic [31:0]      rc_narrowed;
    logic [31:0]      lane_data;
    logic [3:0]       lane_be;
    logic             beat_ovf;
    logic             misalign;
    logic             accept;

    logic             vld_p1;
    logic [31:0]      data_p1;
    logic [3:0]       be_p1;
    logic             ovf_p1;
    logic             mis_p1;
    logic [CNT_W-1:0] cnt_p1;

    narrow_range_check u_check (
        .data      (in_data),
        .size      (in_size),
        .is_signed (in_signed),
        .ovf       (rc_ovf),
        .narrowed  (rc_narrowed)
    );

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage p0: lane placement, byte enables, misalignment
    always_comb begin
        lane_data = rc_narrowed;
        lane_be   = BE_ALL;
        beat_ovf  = rc_ovf;
        misalign  = 1'b0;
        case (in_size)
            SZ_BYTE: begin
                lane_data = {4{rc_narrowed[7:0]}};
                lane_be   = 4'b0001 << in_addr;
            end
            SZ_HALF: begin
                lane_data = {2{rc_narrowed[15:0]}};
                lane_be   = in_addr[1] ? 4'b1100 : 4'b0011;
                misalign  = in_addr[0];
            end
            SZ_WORD: begin
                lane_data = rc_narrowed;
                lane_be   = BE_ALL;
                misalign  = |in_addr;
            end
            default: begin
                // Reserved size: nothing is written and overflow is meaningless.
                beat_ovf = 1'b0;
                misalign = 1'b1;
            end
        endcase
        if (misalign) begin
            lane_data = 32'b0;
            lane_be   = BE_NONE;
        end
    end

    // Stage p1: output register, held until the downstream accepts
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= 32'b0;
            be_p1   <= BE_NONE;
            ovf_p1  <= 1'b0;
            mis_p1  <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= lane_data;
            be_p1   <= lane_be;
            ovf_p1  <= beat_ovf;
            mis_p1  <= misalign;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Misaligned beats never reach memory, so they are not counted.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_p1 <= '0;
        else if (accept && beat_ovf && !misalign && (cnt_p1 != {CNT_W{1'b1}}))
            cnt_p1 <= cnt_p1 + 1'b1;
    end

    assign out_valid    = vld_p1;
    assign out_data     = data_p1;
    assign out_be       = be_p1;
    assign out_ovf      = ovf_p1;
    assign out_misalign = mis_p1;
    assign ovf_count    = cnt_p1;

endmodule

// File: tb/tb_sign_narrowing_unit.sv
module tb_sign_narrowing_unit;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SIGN_NARROW_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [1:0]       in_size;
    logic             in_signed;
    logic [1:0]       in_addr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [3:0]       out_be;
    logic             out_ovf;
    logic             out_misalign;
    logic [CNT_W-1:0] ovf_count;

    always #5 clk = ~clk;

    sign_narrowing_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_size      (in_size),
        .in_signed    (in_signed),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_be       (out_be),
        .out_ovf      (out_ovf),
        .out_misalign (out_misalign),
        .ovf_count    (ovf_count)
    );

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  sz;
        logic        sg;
        logic [1:0]  a;
        logic [31:0] od;
        logic [3:0]  be;
        logic        ovf;
        logic        mis;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void bump_count(input logic ovf, input logic mis);
        if (ovf && !mis && exp_count < CNT_MAX)
            exp_count++;
    endfunction

    // Reference: range check by integer comparison, then lane placement.
    function automatic void ref_model(input logic [31:0] d, input logic [1:0] sz,
                                      input logic sg, input logic [1:0] a,
                                      output logic [31:0] od, output logic [3:0] be,
                                      output logic ovf, output logic mis);
        longint val, lo, hi, cl;
        logic [63:0] bits;
        val = sg ? longint'($signed(d)) : longint'({32'b0, d});
        od = '0; be = '0; ovf = 1'b0; mis = 1'b0;
        case (sz)
            2'b00: begin
                lo = sg ? -128 : 0;
                hi = sg ? 127 : 255;
                ovf = (val < lo) || (val > hi);
                cl = val;
                if (SAT && ovf) cl = (val > hi) ? hi : lo;
                bits = cl;
                od = {4{bits[7:0]}};
                be = 4'(1 << a);
            end
            2'b01: begin
                lo = sg ? -32768 : 0;
                hi = sg ? 32767 : 65535;
                ovf = (val < lo) || (val > hi);
                cl = val;
                if (SAT && ovf) cl = (val > hi) ? hi : lo;
                bits = cl;
                od = {2{bits[15:0]}};
                be = a[1] ? 4'b1100 : 4'b0011;
                mis = a[0];
            end
            2'b10: begin
                od = d;
                be = 4'b1111;
                mis = (a != 2'b00);
            end
            default: mis = 1'b1;
        endcase
        if (mis) begin
            od = '0;
            be = '0;
        end
    endfunction

    function automatic logic [31:0] rand_data();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = $urandom;
            1: r = 32'($urandom_range(0, 511)) - 32'd256;
            2: r = 32'hFFFF0000 | 32'($urandom_range(0, 65535));
            3: r = 32'($urandom_range(0, 65535));
            4: r = 32'($urandom_range(0, 131071)) - 32'd65536;
            default: r = 32'($urandom_range(0, 3)) << 7;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [31:0] d, input logic [1:0] sz, input logic sg, input logic [1:0] a);
        in_valid = 1'b1; in_data = d; in_size = sz; in_signed = sg; in_addr = a;
    endtask

    // Cycle-level random run against the reference, sampled away from posedge.
    task automatic run_random(input int cycles, input bit force_flow, output int transfers);
        logic        m_valid;
        logic [31:0] m_data;
        logic [3:0]  m_be;
        logic        m_ovf, m_mis;
        logic [31:0] nd;
        logic [3:0]  nbe;
        logic        novf, nmis, acc;
        m_valid = 1'b0; m_data = '0; m_be = '0; m_ovf = 1'b0; m_mis = 1'b0;
        transfers = 0;
        for (int c = 0; c < cycles; c++) begin
            out_ready = force_flow ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid  = force_flow ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data   = rand_data();
            in_size   = 2'($urandom_range(0, 3));
            in_signed = 1'($urandom_range(0, 1));
            in_addr   = 2'($urandom_range(0, 3));
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_out_data", out_data, m_data);
                chk("rnd_out_be", 32'(out_be), 32'(m_be));
                chk("rnd_out_ovf", 32'(out_ovf), 32'(m_ovf));
                chk("rnd_out_mis", 32'(out_misalign), 32'(m_mis));
                if (out_ready) transfers++;
            end
            chk("rnd_ovf_count", 32'(ovf_count), 32'(exp_count));
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                ref_model(in_data, in_size, in_signed, in_addr, nd, nbe, novf, nmis);
                m_valid = 1'b1; m_data = nd; m_be = nbe; m_ovf = novf; m_mis = nmis;
                bump_count(novf, nmis);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
        end
        // Drain: one idle cycle so the last beat leaves.
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        if (m_valid) begin
            chk("rnd_drain_data", out_data, m_data);
            transfers++;
        end
        @(negedge clk);
        chk("rnd_drain_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] a_data;

        tbl[0]  = '{32'hFFFFFF80, 2'b00, 1'b1, 2'd2, 32'h80808080, 4'b0100, 1'b0, 1'b0};
        tbl[1]  = '{32'h00000180, 2'b00, 1'b0, 2'd0, SAT ? 32'hFFFFFFFF : 32'h80808080, 4'b0001, 1'b1, 1'b0};
        tbl[2]  = '{32'h00012345, 2'b01, 1'b1, 2'd1, 32'h00000000, 4'b0000, 1'b1, 1'b1};
        tbl[3]  = '{32'h12345678, 2'b10, 1'b0, 2'd0, 32'h12345678, 4'b1111, 1'b0, 1'b0};
        tbl[4]  = '{32'h12345678, 2'b10, 1'b1, 2'd2, 32'h00000000, 4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{32'h0000FFFF, 2'b01, 1'b0, 2'd2, 32'hFFFFFFFF, 4'b1100, 1'b0, 1'b0};
        tbl[6]  = '{32'h00008000, 2'b01, 1'b1, 2'd0, SAT ? 32'h7FFF7FFF : 32'h80008000, 4'b0011, 1'b1, 1'b0};
        tbl[7]  = '{32'hFFFF8000, 2'b01, 1'b1, 2'd2, 32'h80008000, 4'b1100, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000007F, 2'b00, 1'b1, 2'd3, 32'h7F7F7F7F, 4'b1000, 1'b0, 1'b0};
        tbl[9]  = '{32'h00000080, 2'b00, 1'b1, 2'd1, SAT ? 32'h7F7F7F7F : 32'h80808080, 4'b0010, 1'b1, 1'b0};
        tbl[10] = '{32'h12345678, 2'b11, 1'b1, 2'd0, 32'h00000000, 4'b0000, 1'b0, 1'b1};
        tbl[11] = '{32'hFFFFFF00, 2'b00, 1'b0, 2'd0, SAT ? 32'hFFFFFFFF : 32'h00000000, 4'b0001, 1'b1, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_size = '0;
        in_signed = 1'b0; in_addr = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_be", 32'(out_be), 32'd0);
        chk("rst_out_flags", {30'd0, out_ovf, out_misalign}, 32'd0);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table, one beat per cycle, result 1 cycle later.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].d, tbl[i].sz, tbl[i].sg, tbl[i].a);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].od);
            chk($sformatf("tbl%0d_be", i), 32'(out_be), 32'(tbl[i].be));
            chk($sformatf("tbl%0d_ovf", i), 32'(out_ovf), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_mis", i), 32'(out_misalign), 32'(tbl[i].mis));
            bump_count(tbl[i].ovf, tbl[i].mis);
            chk($sformatf("tbl%0d_count", i), 32'(ovf_count), 32'(exp_count));
        end
        @(negedge clk);
        chk("tbl_idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: A held for 3 cycles while B waits, then B in on release.
        out_ready = 1'b0;
        a_data = 32'h11223344;
        drive(a_data, 2'b10, 1'b0, 2'd0);
        @(negedge clk);
        drive(32'h000000AB, 2'b00, 1'b0, 2'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", out_data, a_data);
            chk("bp_out_be", 32'(out_be), 32'hF);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b_data", out_data, 32'hABABABAB);
        chk("bp_b_be", 32'(out_be), 32'b0010);
        @(negedge clk);
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Back-to-back 8 beats at full throughput, then random flow.
        run_random(8, 1'b1, n);
        chk("b2b_transfers", 32'(n), 32'd8);
        run_random(400, 1'b0, n);

        // Reset while a beat is held.
        out_ready = 1'b0;
        drive(32'h00000180, 2'b00, 1'b0, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst2_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_out_data", out_data, 32'd0);
        chk("rst2_out_be", 32'(out_be), 32'd0);
        chk("rst2_out_flags", {30'd0, out_ovf, out_misalign}, 32'd0);
        chk("rst2_ovf_count", 32'(ovf_count), 32'd0);

        // Counter saturation: 20 overflowing beats on a 4-bit counter.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(32'h00000100 + 32'(i), 2'b00, 1'b0, 2'(i));
            @(negedge clk);
            bump_count(1'b1, 1'b0);
            chk($sformatf("sat_count%0d", i), 32'(ovf_count), 32'(exp_count));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("sat_final", 32'(ovf_count), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
